// File: rtl/arc4_pkg.sv
// ARC4 shared types: controller state encoding
// and key / memory sizing helpers.
package arc4_pkg;

  localparam int MEM_DEPTH = 256;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    KSA,
    LEN,
    PRGA
  } state_t;

  function automatic int key_bytes(input int key_w);
    return key_w / 8;
  endfunction

endpackage

// File: rtl/arc4_keystream.sv
// ARC4 keystream engine: owns the S port, runs
// INIT and KSA, then yields one pad per req/ack.
module arc4_keystream
  import arc4_pkg::*;
#(
  parameter int KEY_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [KEY_W-1:0] key,
  input  logic             req,
  output logic             ack,
  output logic [7:0]       pad,
  output logic             done,
  output state_t           phase,
  output logic [7:0]       s_addr,
  input  logic [7:0]       s_rddata,
  output logic [7:0]       s_wrdata,
  output logic             s_wren
);

  localparam int KB  = key_bytes(KEY_W);
  localparam int KIW = (KB > 1) ? $clog2(KB) : 1;

  state_t           phase_q, phase_d;
  logic [2:0]       step_q, step_d;
  logic [7:0]       i_q, i_d, j_q, j_d;
  logic [7:0]       si_q, si_d, sj_q, sj_d;
  logic [7:0]       t_q, t_d;
  logic [KIW-1:0]   kidx_q, kidx_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [7:0]       addr_q, addr_d;
  logic [7:0]       wdata_q, wdata_d;
  logic             wren_q, wren_d;
  logic [7:0]       pad_q, pad_d;
  logic             ack_q, ack_d;
  logic             done_q, done_d;
  logic [7:0]       kb, jk, jp;

  always_comb begin
    kb = 8'(key_q >> (KEY_W - 8 - 8 * int'(kidx_q)));
    jk = j_q + s_rddata + kb;
    jp = j_q + s_rddata;
    phase_d = phase_q;
    step_d  = step_q;
    i_d     = i_q;
    j_d     = j_q;
    si_d    = si_q;
    sj_d    = sj_q;
    t_d     = t_q;
    kidx_d  = kidx_q;
    key_d   = key_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wren_d  = 1'b0;
    pad_d   = pad_q;
    ack_d   = 1'b0;
    done_d  = 1'b0;
    if (start) begin
      phase_d = INIT;
      key_d   = key;
      addr_d  = 8'd0;
      wdata_d = 8'd0;
      wren_d  = 1'b1;
      i_d     = 8'd1;
    end else begin
      case (phase_q)
        INIT: begin
          addr_d  = i_q;
          wdata_d = i_q;
          wren_d  = 1'b1;
          i_d     = i_q + 8'd1;
          if (i_q == 8'(MEM_DEPTH - 1)) begin
            phase_d = KSA;
            step_d  = 3'd0;
            j_d     = 8'd0;
            kidx_d  = '0;
          end
        end
        KSA: begin
          step_d = step_q + 3'd1;
          case (step_q)
            3'd0: addr_d = i_q;
            3'd2: begin
              si_d   = s_rddata;
              j_d    = jk;
              addr_d = jk;
            end
            3'd4: begin
              sj_d    = s_rddata;
              addr_d  = i_q;
              wdata_d = s_rddata;
              wren_d  = 1'b1;
            end
            3'd5: begin
              addr_d  = j_q;
              wdata_d = si_q;
              wren_d  = 1'b1;
              step_d  = 3'd0;
              i_d     = i_q + 8'd1;
              if (int'(kidx_q) == KB - 1) kidx_d = '0;
              else kidx_d = kidx_q + 1'b1;
              if (i_q == 8'hff) begin
                phase_d = PRGA;
                j_d     = 8'd0;
                done_d  = 1'b1;
              end
            end
            default: ;
          endcase
        end
        PRGA: begin
          step_d = step_q + 3'd1;
          case (step_q)
            3'd0: begin
              if (req) begin
                i_d    = i_q + 8'd1;
                addr_d = i_q + 8'd1;
              end else begin
                step_d = 3'd0;
              end
            end
            3'd2: begin
              si_d   = s_rddata;
              j_d    = jp;
              addr_d = jp;
            end
            3'd4: begin
              sj_d   = s_rddata;
              t_d    = si_q + s_rddata;
              addr_d = si_q + s_rddata;
            end
            3'd5: begin
              addr_d  = i_q;
              wdata_d = sj_q;
              wren_d  = 1'b1;
            end
            3'd6: begin
              addr_d  = j_q;
              wdata_d = si_q;
              wren_d  = 1'b1;
              ack_d   = 1'b1;
              step_d  = 3'd0;
              // pad was read before the swap landed
              if (t_q == i_q) pad_d = sj_q;
              else if (t_q == j_q) pad_d = si_q;
              else pad_d = s_rddata;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= IDLE;
      step_q  <= 3'd0;
      i_q     <= 8'd0;
      j_q     <= 8'd0;
      si_q    <= 8'd0;
      sj_q    <= 8'd0;
      t_q     <= 8'd0;
      kidx_q  <= '0;
      key_q   <= '0;
      addr_q  <= 8'd0;
      wdata_q <= 8'd0;
      wren_q  <= 1'b0;
      pad_q   <= 8'd0;
      ack_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      step_q  <= step_d;
      i_q     <= i_d;
      j_q     <= j_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
      t_q     <= t_d;
      kidx_q  <= kidx_d;
      key_q   <= key_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wren_q  <= wren_d;
      pad_q   <= pad_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
    end
  end

  assign s_addr   = addr_q;
  assign s_wrdata = wdata_q;
  assign s_wren   = wren_q;
  assign pad      = pad_q;
  assign ack      = ack_q;
  assign done     = done_q;
  assign phase    = phase_q;

endmodule

// File: rtl/arc4_encrypt.sv
// ARC4 encryptor: length-prefixed pt memory in,
// length-prefixed ct memory out.
module arc4_encrypt
  import arc4_pkg::*;
#(
  parameter int KEY_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic             rdy,
  input  logic [KEY_W-1:0] key,
  output logic [7:0]       s_addr,
  input  logic [7:0]       s_rddata,
  output logic [7:0]       s_wrdata,
  output logic             s_wren,
  output logic [7:0]       pt_addr,
  input  logic [7:0]       pt_rddata,
  output logic [7:0]       ct_addr,
  output logic [7:0]       ct_wrdata,
  output logic             ct_wren
);

  state_t     st_q, st_d;
  logic       rdy_q, rdy_d;
  logic [7:0] len_q, len_d;
  logic [7:0] k_q, k_d;
  logic [7:0] pt_addr_q, pt_addr_d;
  logic [7:0] ct_addr_q, ct_addr_d;
  logic [7:0] ct_wrdata_q, ct_wrdata_d;
  logic       ct_wren_q, ct_wren_d;
  logic       req_q, req_d;
  logic       start, ks_ack, ks_done;
  logic [7:0] ks_pad;
  state_t     ks_phase;

  assign start = en && rdy_q;

  arc4_keystream #(.KEY_W(KEY_W)) u_ks (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .key      (key),
    .req      (req_q),
    .ack      (ks_ack),
    .pad      (ks_pad),
    .done     (ks_done),
    .phase    (ks_phase),
    .s_addr   (s_addr),
    .s_rddata (s_rddata),
    .s_wrdata (s_wrdata),
    .s_wren   (s_wren)
  );

  always_comb begin
    st_d        = st_q;
    rdy_d       = rdy_q;
    len_d       = len_q;
    k_d         = k_q;
    pt_addr_d   = pt_addr_q;
    ct_addr_d   = ct_addr_q;
    ct_wrdata_d = ct_wrdata_q;
    ct_wren_d   = 1'b0;
    req_d       = 1'b0;
    case (st_q)
      IDLE: begin
        if (en) begin
          st_d      = INIT;
          rdy_d     = 1'b0;
          pt_addr_d = 8'd0;
          len_d     = 8'd0;
          k_d       = 8'd0;
        end
      end
      INIT: if (ks_phase == KSA) st_d = KSA;
      KSA:  if (ks_done) st_d = LEN;
      LEN: begin
        // pt[0] has been on the read port since accept
        len_d       = pt_rddata;
        ct_addr_d   = 8'd0;
        ct_wrdata_d = pt_rddata;
        ct_wren_d   = 1'b1;
        if (pt_rddata == 8'd0) begin
          st_d  = IDLE;
          rdy_d = 1'b1;
        end else begin
          st_d      = PRGA;
          k_d       = 8'd1;
          pt_addr_d = 8'd1;
          req_d     = 1'b1;
        end
      end
      PRGA: begin
        if (ks_ack) begin
          ct_addr_d   = k_q;
          ct_wrdata_d = pt_rddata ^ ks_pad;
          ct_wren_d   = 1'b1;
          if (k_q == len_q) begin
            st_d  = IDLE;
            rdy_d = 1'b1;
          end else begin
            k_d       = k_q + 8'd1;
            pt_addr_d = k_q + 8'd1;
            req_d     = 1'b1;
          end
        end
      end
      default: begin
        st_d  = IDLE;
        rdy_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q        <= IDLE;
      rdy_q       <= 1'b1;
      len_q       <= 8'd0;
      k_q         <= 8'd0;
      pt_addr_q   <= 8'd0;
      ct_addr_q   <= 8'd0;
      ct_wrdata_q <= 8'd0;
      ct_wren_q   <= 1'b0;
      req_q       <= 1'b0;
    end else begin
      st_q        <= st_d;
      rdy_q       <= rdy_d;
      len_q       <= len_d;
      k_q         <= k_d;
      pt_addr_q   <= pt_addr_d;
      ct_addr_q   <= ct_addr_d;
      ct_wrdata_q <= ct_wrdata_d;
      ct_wren_q   <= ct_wren_d;
      req_q       <= req_d;
    end
  end

  assign rdy       = rdy_q;
  assign pt_addr   = pt_addr_q;
  assign ct_addr   = ct_addr_q;
  assign ct_wrdata = ct_wrdata_q;
  assign ct_wren   = ct_wren_q;

endmodule

// File: tb/tb_arc4_encrypt.sv
// Bench for arc4_encrypt: behavioural memories,
// software ARC4 reference and directed vectors.
module tb_arc4_encrypt;

  logic        clk = 1'b0;
  logic        rst_n, en, rdy;
  logic [23:0] key;
  logic [7:0]  s_addr, s_rddata, s_wrdata;
  logic        s_wren;
  logic [7:0]  pt_addr, pt_rddata;
  logic [7:0]  ct_addr, ct_wrdata;
  logic        ct_wren;

  always #5 clk = ~clk;

  arc4_encrypt #(.KEY_W(24)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .rdy       (rdy),
    .key       (key),
    .s_addr    (s_addr),
    .s_rddata  (s_rddata),
    .s_wrdata  (s_wrdata),
    .s_wren    (s_wren),
    .pt_addr   (pt_addr),
    .pt_rddata (pt_rddata),
    .ct_addr   (ct_addr),
    .ct_wrdata (ct_wrdata),
    .ct_wren   (ct_wren)
  );

  logic [7:0] smem   [256];
  logic [7:0] ptmem  [256];
  logic [7:0] ctmem  [256];
  logic [7:0] ref_s  [256];
  logic [7:0] ref_ct [256];
  logic [7:0] std_pt [10] = '{8'h09, 8'h50, 8'h6C,
    8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
  logic [7:0] std_ct [10] = '{8'h09, 8'hBB, 8'hF3,
    8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};

  int   wr_cnt = 0, hi_wr = 0, zero_wr = 0, dbl_wr = 0;
  int   cur_len = 0;
  logic ct_wren_d1 = 1'b0;
  int   ncmp = 0, nfail = 0;

  always @(posedge clk) begin
    s_rddata  <= smem[s_addr];
    if (s_wren) smem[s_addr] <= s_wrdata;
    pt_rddata <= ptmem[pt_addr];
    if (ct_wren) begin
      ctmem[ct_addr] <= ct_wrdata;
      wr_cnt++;
      if (ct_addr == 8'd0) zero_wr++;
      if (int'(ct_addr) > cur_len) hi_wr++;
    end
    if (ct_wren && ct_wren_d1) dbl_wr++;
    ct_wren_d1 <= ct_wren;
  end

  typedef struct {
    logic [23:0] key;
    int          len;
    int          kind;
    int          exp_wr;
    int          max_cyc;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string nm, input int got,
                     input int exp);
    ncmp++;
    if (got != exp) begin
      nfail++;
      $display("FAIL %s: got %0d required %0d",
               nm, got, exp);
    end
  endtask

  task automatic fill(input int len, input int kind);
    ptmem[0] = 8'(len);
    for (int i = 1; i < 256; i++) begin
      case (kind)
        0: ptmem[i] = (i < 10) ? std_pt[i] : 8'h00;
        1: ptmem[i] = 8'($urandom);
        2: ptmem[i] = 8'h00;
        default: ptmem[i] = 8'(i * 7);
      endcase
    end
  endtask

  task automatic ref_run(input logic [23:0] k,
                         input int n);
    int         ii, jj;
    logic [7:0] tmp, kb;
    for (int a = 0; a < 256; a++) ref_s[a] = 8'(a);
    jj = 0;
    for (ii = 0; ii < 256; ii++) begin
      kb = k[23 - 8 * (ii % 3) -: 8];
      jj = (jj + int'(ref_s[ii]) + int'(kb)) % 256;
      tmp = ref_s[ii];
      ref_s[ii] = ref_s[jj];
      ref_s[jj] = tmp;
    end
    ref_ct[0] = 8'(n);
    ii = 0;
    jj = 0;
    for (int m = 1; m <= n; m++) begin
      ii = (ii + 1) % 256;
      jj = (jj + int'(ref_s[ii])) % 256;
      tmp = ref_s[ii];
      ref_s[ii] = ref_s[jj];
      ref_s[jj] = tmp;
      tmp = ref_s[(int'(ref_s[ii]) +
                   int'(ref_s[jj])) % 256];
      ref_ct[m] = ptmem[m] ^ tmp;
    end
  endtask

  task automatic wait_rdy(output int cyc);
    cyc = 0;
    while (!rdy && cyc < 6000) begin
      @(negedge clk);
      cyc++;
    end
    chk("rdy_timeout", int'(rdy), 1);
    @(negedge clk);
  endtask

  task automatic run_job(input logic [23:0] k,
                         input int len,
                         output int cyc);
    cur_len = len;
    @(negedge clk);
    en  = 1'b1;
    key = k;
    @(negedge clk);
    en = 1'b0;
    wait_rdy(cyc);
  endtask

  task automatic verify(input string tag,
                        input logic [23:0] k,
                        input int len, input int cyc,
                        input int max_cyc, input int bw,
                        input int bh, input int bz);
    int   mis, smis, seen_n;
    logic seen [256];
    ref_run(k, len);
    mis = 0;
    for (int i = 0; i <= len; i++)
      if (ctmem[i] !== ref_ct[i]) mis++;
    chk({tag, "_ct_bytes"}, mis, 0);
    chk({tag, "_writes"}, wr_cnt - bw, len + 1);
    chk({tag, "_above_len"}, hi_wr - bh, 0);
    chk({tag, "_ct0_writes"}, zero_wr - bz, 1);
    chk({tag, "_budget"}, int'(cyc <= max_cyc), 1);
    smis = 0;
    seen_n = 0;
    for (int i = 0; i < 256; i++) seen[i] = 1'b0;
    for (int i = 0; i < 256; i++) begin
      if (smem[i] !== ref_s[i]) smis++;
      if (!$isunknown(smem[i]) && !seen[smem[i]]) begin
        seen[smem[i]] = 1'b1;
        seen_n++;
      end
    end
    chk({tag, "_s_state"}, smis, 0);
    chk({tag, "_s_perm"}, seen_n, 256);
  endtask

  initial begin
    int cyc, bw, bh, bz, found;
    vecs[0] = '{24'h4B6579, 9, 0, 10, 1868};
    vecs[1] = '{24'h13579B, 0, 1, 1, 1796};
    vecs[2] = '{24'h5EED42, 255, 1, 256, 3836};
    vecs[3] = '{24'h000000, 255, 2, 256, 3836};
    vecs[4] = '{24'hFFFFFF, 255, 2, 256, 3836};
    vecs[5] = '{24'h010203, 1, 3, 2, 1804};

    rst_n = 1'b0;
    en    = 1'b0;
    key   = 24'h0;
    repeat (3) @(negedge clk);
    chk("rst_rdy", int'(rdy), 1);
    chk("rst_s_wren", int'(s_wren), 0);
    chk("rst_ct_wren", int'(ct_wren), 0);
    chk("rst_s_addr", int'(s_addr), 0);
    chk("rst_pt_addr", int'(pt_addr), 0);
    chk("rst_ct_addr", int'(ct_addr), 0);
    chk("rst_s_wrdata", int'(s_wrdata), 0);
    rst_n = 1'b1;

    for (int v = 0; v < 6; v++) begin
      fill(vecs[v].len, vecs[v].kind);
      bw = wr_cnt;
      bh = hi_wr;
      bz = zero_wr;
      run_job(vecs[v].key, vecs[v].len, cyc);
      verify($sformatf("v%0d", v), vecs[v].key,
             vecs[v].len, cyc, vecs[v].max_cyc,
             bw, bh, bz);
      chk($sformatf("v%0d_wr_total", v),
          wr_cnt - bw, vecs[v].exp_wr);
      if (vecs[v].kind == 0)
        for (int i = 0; i < 10; i++)
          chk($sformatf("std_ct%0d", i),
              int'(ctmem[i]), int'(std_ct[i]));
    end

    fill(9, 0);
    cur_len = 9;
    @(negedge clk);
    en  = 1'b1;
    key = 24'h4B6579;
    @(negedge clk);
    en = 1'b0;
    found = 0;
    for (int c = 0; c < 5000 && found == 0; c++) begin
      @(negedge clk);
      if (ct_wren && ct_addr == 8'd4) found = 1;
    end
    chk("midrst_reach_k5", found, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_rdy", int'(rdy), 1);
    chk("midrst_s_wren", int'(s_wren), 0);
    chk("midrst_ct_wren", int'(ct_wren), 0);
    @(negedge clk);
    rst_n = 1'b1;
    bw = wr_cnt;
    bh = hi_wr;
    bz = zero_wr;
    run_job(24'h4B6579, 9, cyc);
    verify("midrst_rerun", 24'h4B6579, 9, cyc, 1868,
           bw, bh, bz);
    for (int i = 0; i < 10; i++)
      chk($sformatf("rerun_ct%0d", i),
          int'(ctmem[i]), int'(std_ct[i]));

    fill(20, 1);
    cur_len = 20;
    bw = wr_cnt;
    bh = hi_wr;
    bz = zero_wr;
    @(negedge clk);
    en  = 1'b1;
    key = 24'hC0FFEE;
    @(negedge clk);
    key = 24'h123456;
    repeat (9) @(negedge clk);
    en = 1'b0;
    wait_rdy(cyc);
    verify("hold_en", 24'hC0FFEE, 20, cyc, 1956,
           bw, bh, bz);
    bw = wr_cnt;
    repeat (5) @(negedge clk);
    chk("idle_rdy", int'(rdy), 1);
    chk("idle_no_writes", wr_cnt - bw, 0);

    fill(1, 3);
    cur_len = 1;
    @(negedge clk);
    en  = 1'b1;
    key = 24'h0A0B0C;
    @(negedge clk);
    wait_rdy(cyc);
    chk("reaccept_rdy_low", int'(rdy), 0);
    en = 1'b0;
    bw = wr_cnt;
    bh = hi_wr;
    bz = zero_wr;
    wait_rdy(cyc);
    verify("reaccept", 24'h0A0B0C, 1, cyc, 1804,
           bw, bh, bz);

    chk("ct_wren_pulse", dbl_wr, 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/arc4_encrypt.md
Name: arc4_encrypt

Overview:
- ARC4 encryptor: reads a length-prefixed plaintext from a 256x8 pt memory and writes a length-prefixed ciphertext to a 256x8 ct memory.
- Uses the 24-bit key and an external 256x8 S memory.
- Mirror of the decryption path: produces ct memories that the existing decrypt/crack tasks consume.
- Sits beside the decrypt/crack top levels, sharing their memory-port style and rdy/en handshake.

Parameters:
- KEY_W, 24, key width in bits; must be a multiple of 8; key length in bytes = KEY_W/8.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  start request, sampled only while rdy=1
- rdy  out  1  high when idle and able to accept en
- key  in  KEY_W  encryption key; byte 0 = key[KEY_W-1 -: 8]; sampled on the accept cycle
- s_addr  out  8  S memory address
- s_rddata  in  8  S read data, valid 1 cycle after address (synchronous read)
- s_wrdata  out  8  S write data
- s_wren  out  1  S write enable
- pt_addr  out  8  plaintext address
- pt_rddata  in  8  plaintext read data, 1-cycle latency
- ct_addr  out  8  ciphertext address
- ct_wrdata  out  8  ciphertext write data
- ct_wren  out  1  ciphertext write enable

Behaviour:
- Reset (async, rst_n=0): state IDLE, rdy=1, all wren=0, all addr/wrdata=0; internal i, j, k, len cleared. Reset mid-operation aborts immediately; partial memory contents are left as-is.
- Handshake: en && rdy at a rising edge = accept. Key is latched and rdy=0 from the next cycle. en while rdy=0 is ignored. rdy returns to 1 only after the final ct write has been issued. An en held high re-accepts on the first rdy=1 cycle.
- States: IDLE -> INIT -> KSA -> LEN -> PRGA -> IDLE.
- INIT: for i=0..255, S[i]=i; exactly 256 cycles, one write per cycle.
- KSA: i=0..255, j starts at 0:
  - j = (j + S[i] + keybyte[i mod (KEY_W/8)]) mod 256, then swap S[i], S[j].
  - At most 6 cycles per iteration.
  - i==j swap must leave S unchanged (write the value read last).
- LEN: read pt[0] into len, write ct[0]=len.
  - len=0: go to IDLE with no further writes.
- PRGA: i=0, j=0, for k=1..len:
  - i=i+1; j=j+S[i]; swap S[i], S[j]; pad = S[(S[i]+S[j]) mod 256].
  - Write ct[k] = pt[k] XOR pad.
  - At most 8 cycles per byte.
  - All index arithmetic is 8-bit wrap-around.
- At most one write strobe is asserted per memory per cycle. Write enables are single-cycle pulses.
- pt is never written. ct addresses above len are never written.
- Swaps use values already read; S reads issued in the same cycle as an S write to the same address are not relied upon.
- Cycle budget: total ≤ 256 + 6·256 + 4 + 8·len cycles from accept to rdy.

Decomposition:
- Package arc4_pkg holds:
  - state enum (IDLE, INIT, KSA, LEN, PRGA)
  - KEY_BYTES localparam helper
  - MEM_DEPTH=256
- One sub-module is natural: arc4_keystream. It owns the S-memory port and runs INIT/KSA/PRGA, giving one pad byte per req/ack. arc4_encrypt wraps it with the pt/ct length and XOR control.
- The shared S-port protocol matches the decrypt path, so arc4_keystream can later replace the duplicated logic there.

Test Plan:
- Standard vector: key=24'h4B6579 ("Key"), pt = 09 followed by "Plaintext" (50 6C 61 69 6E 74 65 78 74), pulse en -> ct[0]=09, ct[1..9] = BB F3 16 E8 D9 40 AF 0A D3, then rdy=1.
- Empty message: pt[0]=00, any key -> exactly one ct write (addr 0, data 00), rdy high within 256+6·256+4 cycles, S holds the post-KSA permutation.
- Round trip: encrypt a random 255-byte message with a random key, feed the ct memory into the existing decrypt block with the same key -> recovered pt bytes 0..255 identical; no ct write to any address >255.
- Reset mid-PRGA: assert rst_n=0 for 1 cycle at k=5 of a 9-byte job -> rdy=1 and wrens=0 immediately. A new en with the same key then produces the full correct vector again.
- Handshake: en held high for 10 cycles during a job -> exactly one job runs per rdy window. en with rdy=0 -> no effect. key changed after accept -> output uses the latched key.
- i==j swap: key=24'h000000 and key=24'hFFFFFF with a 255-byte all-zero pt -> ct equals a reference-model keystream, and a scoreboard confirms S remains a permutation of 0..255 at done.
